spi_req_arbiter: RTL and testbench
==================================

Name: spi_req_arbiter

Overview:
- Round-robin scheduler that shares one SPI master controller among NREQ requesters.
- Accepts one request (address + write data) per transaction.
- Drives the controller's register interface and enable/master lines, then waits for transmit-buffer-empty and transfer-complete.
- Returns the read data, or a timeout error, to the granted requester.
- Sits between the on-chip requesters (CPU bridge, DMA, sequencers) and the SPI controller.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA, 8, data width
ADDR, 3, register address width
TMO, 255, cycle limit per transaction before error (8-bit counter, 1..255)

Ports:
CLK  input  1  clock, rising edge
PRESETn  input  1  asynchronous active-low reset
arb_en  input  1  when 0, no new grants; an in-flight transaction completes
req_valid  input  NREQ  request per requester; held until req_ready seen
req_addr  input  NREQ*ADDR  packed addresses, requester i at [i*ADDR +: ADDR]
req_wdata  input  NREQ*DATA  packed write data, requester i at [i*DATA +: DATA]
req_ready  output  NREQ  one-cycle accept pulse, one-hot
rsp_valid  output  NREQ  one-cycle response pulse, one-hot, to granted requester
rsp_rdata  output  DATA  read data, valid with rsp_valid
rsp_err  output  1  timeout flag, valid with rsp_valid
reg_addr  output  ADDR  to controller
reg_wdata  output  DATA  to controller
SPE  output  1  controller enable
MSTR  output  1  master mode select
SPTEF  input  1  controller transmit buffer empty
TXC  input  1  controller transfer complete
m_rdata  input  DATA  controller read data
busy  output  1  high in any state other than IDLE
grant_id  output  3  index of current or last grant

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = NREQ-1, so requester 0 has first priority. Reset mid-transaction aborts with no rsp_valid.
- All outputs are registered.
- State IDLE:
  - At an edge where arb_en=1 and any req_valid=1, the winner g is the first set bit when scanning from (last_grant+1) mod NREQ upward with wrap.
  - Latch req_addr[g] into reg_addr and req_wdata[g] into reg_wdata; set grant_id=g.
  - Pulse req_ready[g] for exactly the next cycle. Clear the timeout counter. Go to ISSUE.
  - Requesters with req_valid=0 are never granted.
- State ISSUE: SPE=1, MSTR=1. When SPTEF=1 is sampled, go to WAIT_TXC. TXC is ignored in this state.
- State WAIT_TXC: SPE=1, MSTR=1. When TXC=1 is sampled, capture m_rdata into rsp_rdata, set rsp_err=0, go to RESP.
- Timeout:
  - The counter increments every cycle in ISSUE and WAIT_TXC.
  - When the counter equals TMO and the exit condition is not met on that same edge: rsp_rdata=0, rsp_err=1, go to RESP.
  - If the exit condition and TMO coincide, the exit condition wins (no error).
- State RESP:
  - SPE=0, MSTR=0. rsp_valid[g]=1 for exactly one cycle.
  - last_grant=g. Go to IDLE.
  - rsp_rdata and rsp_err hold their values until the next RESP.
- Throughput: minimum 4 cycles per transaction (IDLE, ISSUE, WAIT_TXC, RESP), with SPTEF and TXC already high.
- arb_en falling mid-transaction has no effect until return to IDLE.
- reg_addr and reg_wdata are stable from grant through RESP. req_* changes after acceptance are ignored.
- SPE is deasserted for at least one cycle (RESP) between transactions.
- Invalid state encoding returns to IDLE with outputs cleared.

Test Plan:
- Reset, then req_valid=4'b0001, addr 3'd5, wdata 8'hA5, SPTEF=1, TXC pulsed 3 cycles after SPE: reg_addr=5, reg_wdata=A5, req_ready=0001 for 1 cycle, rsp_valid=0001, rsp_rdata=m_rdata (8'h3C), rsp_err=0.
- req_valid=4'b1111 held continuously for 8 transactions: grant order 0,1,2,3,0,1,2,3; each req_ready pulse is one cycle and one-hot.
- req_valid=4'b1010 after last_grant=1: grant 3, then 1; requesters 0 and 2 are never granted.
- TXC held 0 with TMO=255: rsp_valid after 255 counted cycles, rsp_err=1, rsp_rdata=0, SPE=0 in RESP, next request is granted normally.
- arb_en=0 with req_valid=1: no req_ready, busy=0. Toggle arb_en low during WAIT_TXC: that transaction completes, then no new grant.
- PRESETn asserted during WAIT_TXC: all outputs 0 asynchronously, no rsp_valid. After release, requester 0 has priority.

Source files
------------

// File: rtl/spi_req_arbiter.sv
// Round-robin scheduler sharing one SPI master controller among NREQ requesters.
// A grant drives the controller until transfer complete or timeout, then returns a response.
module spi_req_arbiter #(
    parameter int NREQ = 4,
    parameter int DATA = 8,
    parameter int ADDR = 3,
    parameter int TMO  = 255
) (
    input  logic                 CLK,
    input  logic                 PRESETn,
    input  logic                 arb_en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*ADDR-1:0] req_addr,
    input  logic [NREQ*DATA-1:0] req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DATA-1:0]      rsp_rdata,
    output logic                 rsp_err,
    output logic [ADDR-1:0]      reg_addr,
    output logic [DATA-1:0]      reg_wdata,
    output logic                 SPE,
    output logic                 MSTR,
    input  logic                 SPTEF,
    input  logic                 TXC,
    input  logic [DATA-1:0]      m_rdata,
    output logic                 busy,
    output logic [2:0]           grant_id
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_TXC = 3'd2,
        S_RESP     = 3'd3
    } state_t;

    localparam int unsigned     NR       = NREQ;
    localparam int unsigned     IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]      TMO_CNT  = 8'(TMO);
    localparam logic [2:0]      LAST_RST = 3'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE      = NREQ'(1);

    state_t            r_state, w_state;
    logic [7:0]        r_cnt, w_cnt, w_cnt_inc;
    logic [2:0]        r_last, w_last;
    logic [2:0]        r_grant, w_grant;
    logic [2:0]        w_win;
    logic              w_tmo;
    logic [NREQ-1:0]   r_req_ready, w_req_ready;
    logic [NREQ-1:0]   r_rsp_valid, w_rsp_valid;
    logic [DATA-1:0]   r_rsp_rdata, w_rsp_rdata;
    logic              r_rsp_err, w_rsp_err;
    logic [ADDR-1:0]   r_reg_addr, w_reg_addr;
    logic [DATA-1:0]   r_reg_wdata, w_reg_wdata;
    logic              r_active, w_active;
    logic              r_busy, w_busy;

    // Scan from highest offset down so the nearest requester after r_last wins.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        w_win = r_last;
        for (int unsigned k = NR; k >= 1; k--) begin
            idx = 32'(r_last) + k;
            if (idx >= NR) idx = idx - NR;
            if (req_valid[idx[IW-1:0]]) w_win = 3'(idx);
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_last      = r_last;
        w_grant     = r_grant;
        w_req_ready = '0;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_err   = r_rsp_err;
        w_reg_addr  = r_reg_addr;
        w_reg_wdata = r_reg_wdata;
        w_tmo       = (r_cnt == TMO_CNT);
        // Saturating, so an ISSUE exit on the TMO edge still times out in WAIT_TXC.
        w_cnt_inc   = w_tmo ? r_cnt : r_cnt + 8'd1;

        case (r_state)
            S_IDLE: begin
                if (arb_en && (|req_valid)) begin
                    w_grant     = w_win;
                    w_reg_addr  = req_addr[32'(w_win)*ADDR +: ADDR];
                    w_reg_wdata = req_wdata[32'(w_win)*DATA +: DATA];
                    w_req_ready = ONE << w_win;
                    w_cnt       = '0;
                    w_state     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt = w_cnt_inc;
                if (SPTEF) begin
                    w_state = S_WAIT_TXC;
                end else if (w_tmo) begin
                    w_rsp_rdata = '0;
                    w_rsp_err   = 1'b1;
                    w_state     = S_RESP;
                end
            end
            S_WAIT_TXC: begin
                w_cnt = w_cnt_inc;
                if (TXC) begin
                    w_rsp_rdata = m_rdata;
                    w_rsp_err   = 1'b0;
                    w_state     = S_RESP;
                end else if (w_tmo) begin
                    w_rsp_rdata = '0;
                    w_rsp_err   = 1'b1;
                    w_state     = S_RESP;
                end
            end
            S_RESP: begin
                w_last  = r_grant;
                w_state = S_IDLE;
            end
            default: begin
                w_state     = S_IDLE;
                w_cnt       = '0;
                w_last      = LAST_RST;
                w_grant     = '0;
                w_rsp_rdata = '0;
                w_rsp_err   = 1'b0;
                w_reg_addr  = '0;
                w_reg_wdata = '0;
            end
        endcase

        w_active    = (w_state == S_ISSUE) || (w_state == S_WAIT_TXC);
        w_rsp_valid = (w_state == S_RESP) ? (ONE << r_grant) : '0;
        w_busy      = (w_state != S_IDLE);
    end

    always_ff @(posedge CLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last      <= LAST_RST;
            r_grant     <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_active    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_last      <= w_last;
            r_grant     <= w_grant;
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
            r_reg_addr  <= w_reg_addr;
            r_reg_wdata <= w_reg_wdata;
            r_active    <= w_active;
            r_busy      <= w_busy;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign SPE       = r_active;
    assign MSTR      = r_active;
    assign busy      = r_busy;
    assign grant_id  = r_grant;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: scoreboarded transactions against a behavioural SPI controller.
// Expected grants come from an independent round-robin model; responses are popped on rsp_valid.
module tb_spi_req_arbiter;

    localparam int NREQ = 4;
    localparam int DATA = 8;
    localparam int ADDR = 3;
    localparam int TMO  = 255;
    localparam int AW   = NREQ * ADDR;
    localparam int DW   = NREQ * DATA;

    logic            CLK, PRESETn, arb_en, SPTEF, TXC;
    logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [DATA-1:0] rsp_rdata, reg_wdata, m_rdata;
    logic            rsp_err, SPE, MSTR, busy;
    logic [ADDR-1:0] reg_addr;
    logic [2:0]      grant_id;

    spi_req_arbiter #(.NREQ(NREQ), .DATA(DATA), .ADDR(ADDR), .TMO(TMO)) dut (
        .CLK(CLK), .PRESETn(PRESETn), .arb_en(arb_en),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .SPE(SPE), .MSTR(MSTR), .SPTEF(SPTEF), .TXC(TXC), .m_rdata(m_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0]      id;
        logic [DATA-1:0] rdata;
        logic            err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks, n_pass;
    int   txc_delay, spe_cnt, m_last;

    logic [NREQ-1:0] o_ready, o_rsp;
    logic [DATA-1:0] o_rdata, o_wdata, o_wdata_rsp;
    logic [ADDR-1:0] o_addr, o_addr_rsp;
    logic [2:0]      o_gid;
    logic            o_err, o_got, o_spe_rsp, o_mstr_rsp;
    int              o_ready_cyc, o_spe_cyc;

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] req);
        for (int n = 1; n <= NREQ; n++) begin
            if (req[(last + n) % NREQ]) return (last + n) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // One cycle; the controller model raises TXC txc_delay cycles after SPE rises.
    task automatic step();
        @(negedge CLK);
        if (SPE) begin
            spe_cnt++;
            TXC = (txc_delay >= 0) && (spe_cnt == txc_delay);
        end else begin
            spe_cnt = 0;
            TXC = 1'b0;
        end
    endtask

    task automatic run_txn(input int budget, input bit drop, input int en_off);
        int c = 0;
        o_ready = '0; o_rsp = '0; o_got = 1'b0; o_ready_cyc = 0; o_spe_cyc = 0;
        o_rdata = '0; o_err = 1'b0; o_addr = '0; o_wdata = '0; o_gid = '0;
        o_addr_rsp = '0; o_wdata_rsp = '0; o_spe_rsp = 1'b0; o_mstr_rsp = 1'b0;
        while (c < budget && !o_got) begin
            step();
            if (req_ready != '0) begin
                o_ready_cyc++;
                if (o_ready == '0) begin
                    o_ready = req_ready; o_addr = reg_addr; o_wdata = reg_wdata; o_gid = grant_id;
                end
                if (drop) begin
                    req_valid = req_valid & ~req_ready;
                    req_addr  = AW'($urandom);
                    req_wdata = DW'($urandom);
                end
            end
            if (SPE) o_spe_cyc++;
            if (rsp_valid != '0) begin
                o_got = 1'b1; o_rsp = rsp_valid; o_rdata = rsp_rdata; o_err = rsp_err;
                o_addr_rsp = reg_addr; o_wdata_rsp = reg_wdata; o_spe_rsp = SPE; o_mstr_rsp = MSTR;
            end
            if (c == en_off) arb_en = 1'b0;
            c++;
        end
    endtask

    task automatic apply_reset();
        PRESETn = 1'b0;
        req_valid = '0;
        step();
        step();
        PRESETn = 1'b1;
        m_last = NREQ - 1;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        step();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, reg_addr, reg_wdata, SPE, MSTR, busy, grant_id} !== '0)
            $display("FAIL reset_outputs: got %h, want 0",
                     {req_ready, rsp_valid, rsp_rdata, rsp_err, reg_addr, reg_wdata, SPE, MSTR, busy, grant_id});
        else n_pass++;
        PRESETn = 1'b1;
        m_last = NREQ - 1;
        step();
        step();
        n_checks++;
        if ({req_ready, SPE, busy} !== '0) $display("FAIL idle_no_req: got %b, want 0", {req_ready, SPE, busy});
        else n_pass++;
    endtask

    task automatic test_single();
        arb_en = 1'b1; m_rdata = 8'h3C; txc_delay = 3;
        req_addr = '0; req_wdata = '0;
        req_addr[0 +: ADDR] = 3'd5;
        req_wdata[0 +: DATA] = 8'hA5;
        req_valid = 4'b0001;
        sb.push_back(exp_t'{3'(rr_pick(m_last, req_valid)), 8'h3C, 1'b0});
        run_txn(20, 1'b1, -1);
        e = sb.pop_front(); m_last = int'(e.id);
        n_checks++; if (o_ready !== oh(e.id)) $display("FAIL single_ready: got %b, want %b", o_ready, oh(e.id)); else n_pass++;
        n_checks++; if (o_ready_cyc !== 1) $display("FAIL single_ready_len: got %0d, want 1", o_ready_cyc); else n_pass++;
        n_checks++; if ({o_addr, o_wdata} !== {3'd5, 8'hA5}) $display("FAIL single_reg: got %h/%h, want 5/a5", o_addr, o_wdata); else n_pass++;
        n_checks++; if (o_rsp !== oh(e.id)) $display("FAIL single_rsp: got %b, want %b", o_rsp, oh(e.id)); else n_pass++;
        n_checks++; if ({o_rdata, o_err} !== {e.rdata, e.err}) $display("FAIL single_data: got %h/%b, want %h/%b", o_rdata, o_err, e.rdata, e.err); else n_pass++;
        n_checks++; if ({o_addr_rsp, o_wdata_rsp} !== {3'd5, 8'hA5}) $display("FAIL single_reg_stable: got %h/%h, want 5/a5", o_addr_rsp, o_wdata_rsp); else n_pass++;
        n_checks++; if ({o_spe_rsp, o_mstr_rsp} !== 2'b00) $display("FAIL single_spe_resp: got %b, want 00", {o_spe_rsp, o_mstr_rsp}); else n_pass++;
        n_checks++; if (o_spe_cyc !== 3) $display("FAIL single_spe_cycles: got %0d, want 3", o_spe_cyc); else n_pass++;
        step();
    endtask

    task automatic test_round_robin();
        arb_en = 1'b1;
        apply_reset();
        txc_delay = 2;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            m_rdata = 8'(8'h40 + k);
            sb.push_back(exp_t'{3'(rr_pick(m_last, req_valid)), m_rdata, 1'b0});
            run_txn(20, 1'b0, -1);
            e = sb.pop_front(); m_last = int'(e.id);
            n_checks++; if (o_ready !== oh(e.id)) $display("FAIL rr_ready[%0d]: got %b, want %b", k, o_ready, oh(e.id)); else n_pass++;
            n_checks++; if (o_ready_cyc !== 1) $display("FAIL rr_ready_len[%0d]: got %0d, want 1", k, o_ready_cyc); else n_pass++;
            n_checks++; if (o_gid !== e.id) $display("FAIL rr_grant_id[%0d]: got %0d, want %0d", k, o_gid, e.id); else n_pass++;
            n_checks++; if (o_rsp !== oh(e.id)) $display("FAIL rr_rsp[%0d]: got %b, want %b", k, o_rsp, oh(e.id)); else n_pass++;
            n_checks++; if ({o_rdata, o_err} !== {e.rdata, e.err}) $display("FAIL rr_data[%0d]: got %h/%b, want %h/%b", k, o_rdata, o_err, e.rdata, e.err); else n_pass++;
            n_checks++; if (o_spe_cyc !== 2) $display("FAIL rr_spe_cycles[%0d]: got %0d, want 2", k, o_spe_cyc); else n_pass++;
        end
        req_valid = '0;
        step(); step();
    endtask

    task automatic test_sparse();
        txc_delay = 2; m_rdata = 8'h11;
        req_valid = 4'b0010;
        sb.push_back(exp_t'{3'(rr_pick(m_last, req_valid)), m_rdata, 1'b0});
        run_txn(20, 1'b1, -1);
        e = sb.pop_front(); m_last = int'(e.id);
        n_checks++; if (o_rsp !== oh(e.id)) $display("FAIL sparse_setup_rsp: got %b, want %b", o_rsp, oh(e.id)); else n_pass++;
        step();
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            m_rdata = 8'(8'h20 + k);
            sb.push_back(exp_t'{3'(rr_pick(m_last, req_valid)), m_rdata, 1'b0});
            run_txn(20, 1'b0, -1);
            e = sb.pop_front(); m_last = int'(e.id);
            n_checks++; if (o_ready !== oh(e.id)) $display("FAIL sparse_ready[%0d]: got %b, want %b", k, o_ready, oh(e.id)); else n_pass++;
            n_checks++; if (o_rsp !== oh(e.id)) $display("FAIL sparse_rsp[%0d]: got %b, want %b", k, o_rsp, oh(e.id)); else n_pass++;
        end
        req_valid = '0;
        step(); step();
    endtask

    task automatic test_timeout();
        txc_delay = -1; m_rdata = 8'hEE;
        req_valid = 4'b0001;
        sb.push_back(exp_t'{3'(rr_pick(m_last, req_valid)), 8'h00, 1'b1});
        run_txn(TMO + 20, 1'b1, -1);
        e = sb.pop_front(); m_last = int'(e.id);
        n_checks++; if (o_rsp !== oh(e.id)) $display("FAIL tmo_rsp: got %b, want %b", o_rsp, oh(e.id)); else n_pass++;
        n_checks++; if ({o_rdata, o_err} !== {e.rdata, e.err}) $display("FAIL tmo_data: got %h/%b, want %h/%b", o_rdata, o_err, e.rdata, e.err); else n_pass++;
        n_checks++; if (o_spe_cyc !== TMO + 1) $display("FAIL tmo_cycles: got %0d, want %0d", o_spe_cyc, TMO + 1); else n_pass++;
        n_checks++; if ({o_spe_rsp, o_mstr_rsp} !== 2'b00) $display("FAIL tmo_spe_resp: got %b, want 00", {o_spe_rsp, o_mstr_rsp}); else n_pass++;
        txc_delay = 3; m_rdata = 8'hC3;
        req_valid = 4'b0100;
        sb.push_back(exp_t'{3'(rr_pick(m_last, req_valid)), m_rdata, 1'b0});
        run_txn(20, 1'b1, -1);
        e = sb.pop_front(); m_last = int'(e.id);
        n_checks++; if (o_rsp !== oh(e.id)) $display("FAIL after_tmo_rsp: got %b, want %b", o_rsp, oh(e.id)); else n_pass++;
        n_checks++; if ({o_rdata, o_err} !== {e.rdata, e.err}) $display("FAIL after_tmo_data: got %h/%b, want %h/%b", o_rdata, o_err, e.rdata, e.err); else n_pass++;
        step(); step();
    endtask

    task automatic test_tmo_coincide();
        txc_delay = TMO + 1; m_rdata = 8'h5A;
        req_valid = 4'b0001;
        sb.push_back(exp_t'{3'(rr_pick(m_last, req_valid)), m_rdata, 1'b0});
        run_txn(TMO + 20, 1'b1, -1);
        e = sb.pop_front(); m_last = int'(e.id);
        n_checks++; if ({o_rsp, o_rdata, o_err} !== {oh(e.id), e.rdata, e.err})
            $display("FAIL tmo_edge_exit: got %b/%h/%b, want %b/%h/%b", o_rsp, o_rdata, o_err, oh(e.id), e.rdata, e.err);
        else n_pass++;
        txc_delay = TMO + 2;
        req_valid = 4'b0010;
        sb.push_back(exp_t'{3'(rr_pick(m_last, req_valid)), 8'h00, 1'b1});
        run_txn(TMO + 20, 1'b1, -1);
        e = sb.pop_front(); m_last = int'(e.id);
        n_checks++; if ({o_rsp, o_rdata, o_err} !== {oh(e.id), e.rdata, e.err})
            $display("FAIL tmo_edge_late: got %b/%h/%b, want %b/%h/%b", o_rsp, o_rdata, o_err, oh(e.id), e.rdata, e.err);
        else n_pass++;
        step(); step();
    endtask

    task automatic test_arb_en();
        logic seen, b;
        arb_en = 1'b0; req_valid = 4'b0001;
        seen = 1'b0; b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            seen |= (req_ready != '0);
            b |= busy;
        end
        n_checks++; if ({seen, b} !== 2'b00) $display("FAIL arb_off_idle: got ready=%b busy=%b, want 0/0", seen, b); else n_pass++;
        req_valid = 4'b1111; arb_en = 1'b1; txc_delay = 5; m_rdata = 8'h77;
        sb.push_back(exp_t'{3'(rr_pick(m_last, req_valid)), m_rdata, 1'b0});
        run_txn(30, 1'b0, 3);
        e = sb.pop_front(); m_last = int'(e.id);
        n_checks++; if (o_rsp !== oh(e.id)) $display("FAIL arb_drop_rsp: got %b, want %b", o_rsp, oh(e.id)); else n_pass++;
        n_checks++; if ({o_rdata, o_err} !== {e.rdata, e.err}) $display("FAIL arb_drop_data: got %h/%b, want %h/%b", o_rdata, o_err, e.rdata, e.err); else n_pass++;
        seen = 1'b0; b = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            seen |= (req_ready != '0);
            b |= (k > 0) && busy;
        end
        n_checks++; if ({seen, b} !== 2'b00) $display("FAIL arb_drop_no_grant: got ready=%b busy=%b, want 0/0", seen, b); else n_pass++;
        req_valid = '0; arb_en = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        logic seen;
        txc_delay = -1; arb_en = 1'b1;
        req_valid = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            step();
            if (req_ready != '0) req_valid = '0;
        end
        #2 PRESETn = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, reg_addr, reg_wdata, SPE, MSTR, busy, grant_id} !== '0)
            $display("FAIL async_reset: got %h, want 0",
                     {req_ready, rsp_valid, rsp_rdata, rsp_err, reg_addr, reg_wdata, SPE, MSTR, busy, grant_id});
        else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            seen |= (rsp_valid != '0);
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL reset_no_rsp: got %b, want 0", seen); else n_pass++;
        req_valid = 4'b1111; PRESETn = 1'b1; m_last = NREQ - 1;
        txc_delay = 2; m_rdata = 8'h99;
        sb.push_back(exp_t'{3'(rr_pick(m_last, req_valid)), m_rdata, 1'b0});
        run_txn(20, 1'b0, -1);
        e = sb.pop_front(); m_last = int'(e.id);
        n_checks++; if (o_ready !== oh(e.id)) $display("FAIL post_reset_ready: got %b, want %b", o_ready, oh(e.id)); else n_pass++;
        n_checks++; if ({o_rsp, o_rdata, o_err} !== {oh(e.id), e.rdata, e.err})
            $display("FAIL post_reset_rsp: got %b/%h/%b, want %b/%h/%b", o_rsp, o_rdata, o_err, oh(e.id), e.rdata, e.err);
        else n_pass++;
        req_valid = '0;
        step(); step();
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        PRESETn = 1'b0; arb_en = 1'b0; SPTEF = 1'b1; TXC = 1'b0;
        req_valid = '0; req_addr = '0; req_wdata = '0; m_rdata = '0;
        txc_delay = -1; spe_cnt = 0; m_last = NREQ - 1;
        test_reset();
        test_single();
        test_round_robin();
        test_sparse();
        test_timeout();
        test_tmo_coincide();
        test_arb_en();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
